// File: rtl/perf_counter_reader_if.sv
// Read port of the performance-counter block: request/address from the reader,
// one-cycle acknowledge and 32-bit data back from the counter block.
interface perf_counter_reader_if;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data
  );
endinterface

// File: rtl/perf_counter_reader.sv
// Cycle / retired-instruction counters fed by the commit stage, frozen on halt
// or run timeout, read through a fixed-latency request/acknowledge port.
// A read of address 0 latches both counters into a snapshot so that the wide
// values can be read back coherently over several 32-bit reads.
module perf_counter_reader #(
  parameter int CYC_W   = 40,
  parameter int INS_W   = 40,
  parameter int TIMEOUT = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  retire_v,
  input  logic                  halt,
  input  logic                  clr,
  perf_counter_reader_if.slave  rd_bus,
  output logic                  halted,
  output logic                  timed_out
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HALTED  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  logic [1:0]       state, state_nxt;
  logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
  logic [INS_W-1:0] ins_cnt, ins_nxt;
  logic [CYC_W-1:0] snap_cyc;
  logic [INS_W-1:0] snap_ins;
  logic [31:0]      rd_word;
  logic             snap_take;

  // Next counter/state values: clr wins over everything, counting only in RUN,
  // and halt takes priority over a timeout landing on the same edge.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    ins_nxt   = ins_cnt;
    if (clr) begin
      state_nxt = ST_RUN;
      cyc_nxt   = '0;
      ins_nxt   = '0;
    end else if (state == ST_RUN) begin
      cyc_nxt = cyc_cnt + 1'b1;
      if (retire_v) begin
        ins_nxt = ins_cnt + 1'b1;
      end
      if (halt) begin
        state_nxt = ST_HALTED;
      end else if (TO_EN && (cyc_cnt == TO_LAST)) begin
        state_nxt = ST_TIMEOUT;
      end
    end
  end

  // Counter and state registers, with halted/timed_out decoded from the next
  // state so they line up with the state register itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      cyc_cnt   <= '0;
      ins_cnt   <= '0;
      halted    <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      cyc_cnt   <= cyc_nxt;
      ins_cnt   <= ins_nxt;
      halted    <= (state_nxt == ST_HALTED);
      timed_out <= (state_nxt == ST_TIMEOUT);
    end
  end

  assign snap_take = rd_bus.rd_req && (rd_bus.rd_addr == 3'd0);

  // Snapshot capture on an address-0 read; takes the pre-edge counts, so a
  // read coinciding with clr still sees the values being cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_cyc <= '0;
      snap_ins <= '0;
    end else if (snap_take) begin
      snap_cyc <= cyc_cnt;
      snap_ins <= ins_cnt;
    end
  end

  // Read address decode; upper halves are zero-extended from the snapshot.
  always_comb begin
    rd_word = '0;
    case (rd_bus.rd_addr)
      3'd0:    rd_word = cyc_cnt[31:0];
      3'd1:    rd_word = 32'(snap_cyc >> 32);
      3'd2:    rd_word = snap_ins[31:0];
      3'd3:    rd_word = 32'(snap_ins >> 32);
      3'd4:    rd_word = {29'b0, timed_out, halted, (state == ST_RUN)};
      default: rd_word = '0;
    endcase
  end

  // Read response register: one ack per request, data held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bus.rd_ack  <= 1'b0;
      rd_bus.rd_data <= '0;
    end else begin
      rd_bus.rd_ack <= rd_bus.rd_req;
      if (rd_bus.rd_req) begin
        rd_bus.rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Bench for perf_counter_reader: a reference model predicts each read result
// into a queue at the sampling edge, and the response is popped and compared
// on the following falling edge. A second instance with timeout disabled is
// used for the wide-counter carry and wrap cases.
module tb_perf_counter_reader;

  localparam logic [1:0] M_RUN     = 2'd0;
  localparam logic [1:0] M_HALTED  = 2'd1;
  localparam logic [1:0] M_TIMEOUT = 2'd2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic retire_v = 1'b0;
  logic halt     = 1'b0;
  logic clr      = 1'b0;
  logic halted_a, timed_out_a;
  logic halted_w, timed_out_w;

  perf_counter_reader_if a_if ();
  perf_counter_reader_if w_if ();

  int tests_run    = 0;
  int tests_failed = 0;

  logic [39:0] m_cyc, m_ins, m_snap_cyc, m_snap_ins;
  logic [1:0]  m_state;
  logic [31:0] q_a[$];
  logic [31:0] q_w[$];
  logic [31:0] w_exp;

  perf_counter_reader #(.CYC_W(40), .INS_W(40), .TIMEOUT(50)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .retire_v  (retire_v),
    .halt      (halt),
    .clr       (clr),
    .rd_bus    (a_if),
    .halted    (halted_a),
    .timed_out (timed_out_a)
  );

  perf_counter_reader #(.CYC_W(40), .INS_W(40), .TIMEOUT(0)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .retire_v  (1'b0),
    .halt      (1'b0),
    .clr       (1'b0),
    .rd_bus    (w_if),
    .halted    (halted_w),
    .timed_out (timed_out_w)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ret, input logic hlt, input logic cl,
                               input logic req, input logic [2:0] addr);
    @(negedge clk);
    retire_v     = ret;
    halt         = hlt;
    clr          = cl;
    a_if.rd_req  = req;
    a_if.rd_addr = addr;
  endtask

  // Reference model of the counters; predicts read data at the sampling edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc      <= '0;
      m_ins      <= '0;
      m_snap_cyc <= '0;
      m_snap_ins <= '0;
      m_state    <= M_RUN;
      q_a.delete();
    end else begin
      if (a_if.rd_req) begin
        case (a_if.rd_addr)
          3'd0: begin
            q_a.push_back(m_cyc[31:0]);
            m_snap_cyc <= m_cyc;
            m_snap_ins <= m_ins;
          end
          3'd1: q_a.push_back({24'b0, m_snap_cyc[39:32]});
          3'd2: q_a.push_back(m_snap_ins[31:0]);
          3'd3: q_a.push_back({24'b0, m_snap_ins[39:32]});
          3'd4: q_a.push_back({29'b0, m_state == M_TIMEOUT, m_state == M_HALTED, m_state == M_RUN});
          default: q_a.push_back(32'h0);
        endcase
      end
      if (clr) begin
        m_cyc   <= '0;
        m_ins   <= '0;
        m_state <= M_RUN;
      end else if (m_state == M_RUN) begin
        m_cyc <= m_cyc + 40'd1;
        if (retire_v) m_ins <= m_ins + 40'd1;
        if (halt) m_state <= M_HALTED;
        else if (m_cyc == 40'd49) m_state <= M_TIMEOUT;
      end
    end
  end

  // Expected data for the wide-counter instance is set by the stimulus.
  always @(posedge clk) begin
    if (rst_n && w_if.rd_req) q_w.push_back(w_exp);
  end

  // Response checker, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset_ack", {63'b0, a_if.rd_ack}, 64'd0);
      checkOutput("reset_data", {32'b0, a_if.rd_data}, 64'd0);
      checkOutput("reset_halted", {63'b0, halted_a}, 64'd0);
      checkOutput("reset_timed_out", {63'b0, timed_out_a}, 64'd0);
      checkOutput("reset_ack_w", {63'b0, w_if.rd_ack}, 64'd0);
      q_w.delete();
    end else begin
      if (q_a.size() != 0) begin
        checkOutput("ack", {63'b0, a_if.rd_ack}, 64'd1);
        checkOutput("rd_data", {32'b0, a_if.rd_data}, {32'b0, q_a.pop_front()});
      end else begin
        checkOutput("ack_idle", {63'b0, a_if.rd_ack}, 64'd0);
      end
      checkOutput("halted", {63'b0, halted_a}, {63'b0, m_state == M_HALTED});
      checkOutput("timed_out", {63'b0, timed_out_a}, {63'b0, m_state == M_TIMEOUT});
      if (q_w.size() != 0) begin
        checkOutput("ack_w", {63'b0, w_if.rd_ack}, 64'd1);
        checkOutput("rd_data_w", {32'b0, w_if.rd_data}, {32'b0, q_w.pop_front()});
      end else begin
        checkOutput("ack_w_idle", {63'b0, w_if.rd_ack}, 64'd0);
      end
      checkOutput("halted_w", {63'b0, halted_w}, 64'd0);
      checkOutput("timed_out_w", {63'b0, timed_out_w}, 64'd0);
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    automatic logic [2:0] b2b_addrs[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    a_if.rd_req  = 1'b0;
    a_if.rd_addr = 3'd0;
    w_if.rd_req  = 1'b0;
    w_if.rd_addr = 3'd0;
    w_exp        = 32'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Cycles 0-11: idle with retire_v on cycles 3-7.
    for (int c = 0; c < 12; c++) applyStimulus(c >= 3 && c <= 7, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);   // 12: cycles = 12
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);   // 13: instructions = 5
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd1);   // 14: 0
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd3);   // 15: 0
    for (int c = 16; c < 20; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // 20: halt with retire; 21-24 retire pulses must be ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int c = 21; c < 25; c++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);   // 25: frozen at 21
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);   // 26: 6
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd4);   // 27: status 0x2

    // 28: clr in HALTED with a snapshot read in the same cycle.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);   // returns 21
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);   // pre-clear 6
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd4);   // status 0x1
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);   // small count 2

    // 32-37: back-to-back reads while counting continues.
    foreach (b2b_addrs[i]) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, b2b_addrs[i]);

    // Run into the timeout (cycle count reaches 50 at edge 78).
    for (int c = 38; c < 80; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd4);   // status 0x4
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);   // frozen at 50

    // Clear, then halt on the same edge the timeout would fire.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int j = 0; j < 49; j++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);   // count 49 -> 50, HALTED
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd4);   // status 0x2
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);   // 50

    // Reset while a read response is outstanding.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    a_if.rd_req = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd4);   // status 0x1 after reset
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Wide counter: carry out of bit 31 and wrap at 2^40.
    @(negedge clk);
    force dut_w.cyc_cnt = 40'h1_FFFF_FFFE;
    #1 release dut_w.cyc_cnt;
    w_if.rd_req = 1'b1; w_if.rd_addr = 3'd0; w_exp = 32'hFFFF_FFFE;
    @(negedge clk);
    w_if.rd_addr = 3'd1; w_exp = 32'h1;
    @(negedge clk);
    w_if.rd_addr = 3'd0; w_exp = 32'h0;
    @(negedge clk);
    w_if.rd_addr = 3'd1; w_exp = 32'h2;
    @(negedge clk);
    w_if.rd_req = 1'b0;
    force dut_w.cyc_cnt = 40'hFF_FFFF_FFFF;
    #1 release dut_w.cyc_cnt;
    @(negedge clk);
    w_if.rd_req = 1'b1; w_if.rd_addr = 3'd0; w_exp = 32'h0;
    @(negedge clk);
    w_if.rd_addr = 3'd1; w_exp = 32'h0;
    @(negedge clk);
    w_if.rd_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
